// File: rtl/alarm_status_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_status_ctrl
//   Alarm-system supervisor placed in front of the LCD message stage. It
//   synchronises and debounces the arm key, intrusion sensor and panic switch,
//   runs the OFF / ARMED / PENDING / ALARM / DANGER state machine and drives
//   the LCD message code, the buzzer and the entry-pending LED.
//
// Ports
//   iCLK       in   1  system clock (50 MHz nominal)
//   iRST_N     in   1  asynchronous, active-low reset
//   iKEY_ARM   in   1  arm/disarm pushbutton, active-low (pressed = 0)
//   iSENSOR    in   1  intrusion sensor, active-high
//   iPANIC     in   1  panic switch, active-high
//   oMESG      out  2  0=OFF, 1=ARMED/PENDING, 2=ALARM, 3=DANGER
//   oBUZZER    out  1  buzzer drive
//   oLED_PEND  out  1  high while the entry delay runs
// -----------------------------------------------------------------------------
module alarm_status_ctrl #(
  parameter int DEB_CYC   = 500000,
  parameter int ENTRY_CYC = 250000000,
  parameter int ESC_CYC   = 500000000,
  parameter int BEEP_HALF = 12500000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iKEY_ARM,
  input  logic       iSENSOR,
  input  logic       iPANIC,
  output logic [1:0] oMESG,
  output logic       oBUZZER,
  output logic       oLED_PEND
);

  localparam int DW = (DEB_CYC   > 1) ? $clog2(DEB_CYC)   : 1;
  localparam int EW = (ENTRY_CYC > 1) ? $clog2(ENTRY_CYC) : 1;
  localparam int SW = (ESC_CYC   > 1) ? $clog2(ESC_CYC)   : 1;
  localparam int BW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [DW-1:0] DEB_TERM = DW'(DEB_CYC - 1);
  localparam logic [EW-1:0] ENT_TERM = EW'(ENTRY_CYC - 1);
  localparam logic [SW-1:0] ESC_TERM = SW'(ESC_CYC - 1);
  localparam logic [BW-1:0] BEP_TERM = BW'(BEEP_HALF - 1);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [EW-1:0] ENT_ONE  = EW'(1);
  localparam logic [SW-1:0] ESC_ONE  = SW'(1);
  localparam logic [BW-1:0] BEP_ONE  = BW'(1);

  // Input vector order: [0]=key, [1]=sensor, [2]=panic. Idle: key released.
  localparam logic [2:0] IDLE_LVL = 3'b001;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_ARMED  = 3'd1,
    ST_PEND   = 3'd2,
    ST_ALARM  = 3'd3,
    ST_DANGER = 3'd4
  } state_t;

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    db_q, db_d;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];

  logic key_dly_q, key_ev_q;
  logic panic_dly_q, panic_ev_q;
  logic sensor_q, panic_lvl_q;

  state_t        state_q, state_d;
  logic [EW-1:0] ent_q, ent_d;
  logic [SW-1:0] esc_q, esc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          buz_q, buz_d;
  logic [1:0]    mesg_q, mesg_d;
  logic          led_q, led_d;

  // Two-flop synchronisers for all three raw inputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= IDLE_LVL;
      sync2_q <= IDLE_LVL;
    end else begin
      sync1_q <= {iPANIC, iSENSOR, iKEY_ARM};
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count consecutive disagreeing samples, accept the
  // new level on the DEB_CYC-th one.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = {DW{1'b0}};
      if (sync2_q[i] != db_q[i]) begin
        if (deb_cnt_q[i] == DEB_TERM) begin
          db_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
        end
      end else begin
        deb_cnt_d[i] = {DW{1'b0}};
      end
    end
  end

  // Debounced levels and their counters.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      db_q <= IDLE_LVL;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= {DW{1'b0}};
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Event/level register stage; sensor and panic levels go through the same
  // stage so every input reaches the FSM with identical latency.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      key_dly_q   <= 1'b1;
      key_ev_q    <= 1'b0;
      panic_dly_q <= 1'b0;
      panic_ev_q  <= 1'b0;
      sensor_q    <= 1'b0;
      panic_lvl_q <= 1'b0;
    end else begin
      key_dly_q   <= db_q[0];
      key_ev_q    <= key_dly_q & ~db_q[0];
      panic_dly_q <= db_q[2];
      panic_ev_q  <= ~panic_dly_q & db_q[2];
      sensor_q    <= db_q[1];
      panic_lvl_q <= db_q[2];
    end
  end

  // FSM next-state, timers and registered-output next values.
  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    esc_d   = esc_q;
    beep_d  = beep_q;
    buz_d   = 1'b0;
    mesg_d  = 2'd0;
    led_d   = 1'b0;

    if (panic_ev_q) begin
      state_d = ST_DANGER;
    end else if (key_ev_q) begin
      case (state_q)
        ST_OFF:    state_d = ST_ARMED;
        ST_DANGER: state_d = panic_lvl_q ? ST_DANGER : ST_OFF;
        default:   state_d = ST_OFF;
      endcase
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (sensor_q) begin
            state_d = ST_PEND;
            ent_d   = {EW{1'b0}};
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_PEND: begin
          if (ent_q == ENT_TERM) begin
            state_d = ST_ALARM;
          end else begin
            ent_d = ent_q + ENT_ONE;
          end
        end
        ST_ALARM: begin
          // Escalation needs an unbroken run of sensor activity.
          if (!sensor_q) begin
            esc_d = {SW{1'b0}};
          end else if (esc_q == ESC_TERM) begin
            state_d = ST_DANGER;
          end else begin
            esc_d = esc_q + ESC_ONE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    case (state_d)
      ST_OFF:   mesg_d = 2'd0;
      ST_ARMED: mesg_d = 2'd1;
      ST_PEND: begin
        mesg_d = 2'd1;
        led_d  = 1'b1;
      end
      ST_ALARM: begin
        mesg_d = 2'd2;
        if (state_q != ST_ALARM) begin
          // Fresh entry: buzzer starts high, beep and escalation restart.
          buz_d  = 1'b1;
          beep_d = {BW{1'b0}};
          esc_d  = {SW{1'b0}};
        end else if (beep_q == BEP_TERM) begin
          buz_d  = ~buz_q;
          beep_d = {BW{1'b0}};
        end else begin
          buz_d  = buz_q;
          beep_d = beep_q + BEP_ONE;
        end
      end
      ST_DANGER: begin
        mesg_d = 2'd3;
        buz_d  = 1'b1;
      end
      default: mesg_d = 2'd0;
    endcase
  end

  // State, timers and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_OFF;
      ent_q   <= {EW{1'b0}};
      esc_q   <= {SW{1'b0}};
      beep_q  <= {BW{1'b0}};
      buz_q   <= 1'b0;
      mesg_q  <= 2'd0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      esc_q   <= esc_d;
      beep_q  <= beep_d;
      buz_q   <= buz_d;
      mesg_q  <= mesg_d;
      led_q   <= led_d;
    end
  end

  assign oMESG     = mesg_q;
  assign oBUZZER   = buz_q;
  assign oLED_PEND = led_q;

endmodule

// File: tb/tb_alarm_status_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_status_ctrl
//   Directed scenarios followed by randomized input segments. A behavioural
//   model tracks raw-input history windows, debounced-level history and
//   timestamps of state entries, and predicts all outputs every cycle.
// -----------------------------------------------------------------------------
module tb_alarm_status_ctrl;

  localparam int DEB   = 4;
  localparam int ENTRY = 20;
  localparam int ESC   = 30;
  localparam int BEEP  = 5;

  localparam int M_OFF    = 0;
  localparam int M_ARMED  = 1;
  localparam int M_PEND   = 2;
  localparam int M_ALARM  = 3;
  localparam int M_DANGER = 4;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iKEY_ARM;
  logic       iSENSOR;
  logic       iPANIC;
  logic [1:0] oMESG;
  logic       oBUZZER;
  logic       oLED_PEND;

  int n_checks = 0;
  int n_errs   = 0;

  alarm_status_ctrl #(
    .DEB_CYC  (DEB),
    .ENTRY_CYC(ENTRY),
    .ESC_CYC  (ESC),
    .BEEP_HALF(BEEP)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iKEY_ARM (iKEY_ARM),
    .iSENSOR  (iSENSOR),
    .iPANIC   (iPANIC),
    .oMESG    (oMESG),
    .oBUZZER  (oBUZZER),
    .oLED_PEND(oLED_PEND)
  );

  always #5 iCLK = ~iCLK;

  // Model state. Raw histories: bit 0 newest sample.
  logic [DEB+1:0] hk, hs, hp;
  // Debounced histories: [0]=previous edge, [1]=two back, [2]=three back.
  logic [2:0] dkh, dsh, dph;
  int mstate, n, pend_t, alarm_t, run_t;
  int exp_mesg, exp_buz, exp_led;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    hk = {(DEB+2){1'b1}};
    hs = '0;
    hp = '0;
    dkh = 3'b111;
    dsh = 3'b000;
    dph = 3'b000;
    mstate = M_OFF;
    n = 0;
    pend_t = 0;
    alarm_t = 0;
    run_t = 0;
    exp_mesg = 0;
    exp_buz = 0;
    exp_led = 0;
  endtask

  // A level flips once the last DEB synchronised samples all disagree with it.
  function automatic logic deb_level(input logic lvl, input logic [DEB+1:0] h);
    logic [DEB-1:0] win;
    win = h[DEB+1:2];
    if (lvl ? (win == '0) : (&win)) return ~lvl;
    return lvl;
  endfunction

  task automatic model_step();
    logic evk, evp, sens, plvl;
    int prev;
    n++;
    hk = {hk[DEB:0], iKEY_ARM};
    hs = {hs[DEB:0], iSENSOR};
    hp = {hp[DEB:0], iPANIC};
    // FSM sees debounced values two edges old; events compare two and three back.
    evk  = dkh[2] & ~dkh[1];
    evp  = ~dph[2] & dph[1];
    sens = dsh[1];
    plvl = dph[1];
    prev = mstate;
    if (evp) mstate = M_DANGER;
    else if (evk) begin
      if (mstate == M_OFF) mstate = M_ARMED;
      else if (mstate == M_DANGER) mstate = plvl ? M_DANGER : M_OFF;
      else mstate = M_OFF;
    end else if (mstate == M_ARMED && sens) begin
      mstate = M_PEND;
      pend_t = n;
    end else if (mstate == M_PEND && (n - pend_t) == ENTRY) begin
      mstate = M_ALARM;
    end else if (mstate == M_ALARM) begin
      if (!sens) run_t = n;
      else if ((n - run_t) == ESC) mstate = M_DANGER;
    end
    if (mstate == M_ALARM && prev != M_ALARM) begin
      alarm_t = n;
      run_t = n;
    end
    case (mstate)
      M_OFF:    exp_mesg = 0;
      M_ARMED:  exp_mesg = 1;
      M_PEND:   exp_mesg = 1;
      M_ALARM:  exp_mesg = 2;
      default:  exp_mesg = 3;
    endcase
    exp_led = (mstate == M_PEND) ? 1 : 0;
    if (mstate == M_DANGER) exp_buz = 1;
    else if (mstate == M_ALARM) exp_buz = (((n - alarm_t) / BEEP) % 2 == 0) ? 1 : 0;
    else exp_buz = 0;
    dkh = {dkh[1:0], deb_level(dkh[0], hk)};
    dsh = {dsh[1:0], deb_level(dsh[0], hs)};
    dph = {dph[1:0], deb_level(dph[0], hp)};
  endtask

  task automatic run_cycle();
    @(posedge iCLK);
    model_step();
    @(negedge iCLK);
    check_eq("mesg", int'(oMESG), exp_mesg);
    check_eq("buzzer", int'(oBUZZER), exp_buz);
    check_eq("led_pend", int'(oLED_PEND), exp_led);
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) run_cycle();
  endtask

  task automatic press_key();
    iKEY_ARM = 1'b0;
    hold(10);
    iKEY_ARM = 1'b1;
    hold(10);
  endtask

  initial begin
    int lat, t_pend, t_alarm, t_dng;
    int alarm_seen;
    iRST_N = 1'b0;
    iKEY_ARM = 1'b1;
    iSENSOR = 1'b0;
    iPANIC = 1'b0;
    model_reset();
    repeat (3) @(negedge iCLK);
    check_eq("rst_mesg", int'(oMESG), 0);
    check_eq("rst_buzzer", int'(oBUZZER), 0);
    check_eq("rst_led", int'(oLED_PEND), 0);
    iRST_N = 1'b1;

    // Arm: OFF -> ARMED exactly DEB+4 edges after the press.
    lat = 0;
    iKEY_ARM = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      run_cycle();
      if (lat == 0 && oMESG == 2'd1) lat = i;
    end
    check_eq("arm_latency", lat, DEB + 4);
    iKEY_ARM = 1'b1;
    hold(10);

    // Sensor: PENDING, ALARM after ENTRY, DANGER after ESC of continuous sensor.
    t_pend = 0; t_alarm = 0; t_dng = 0;
    iSENSOR = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      run_cycle();
      if (t_pend == 0 && oLED_PEND == 1'b1) t_pend = i;
      if (t_alarm == 0 && oMESG == 2'd2) t_alarm = i;
      if (t_dng == 0 && oMESG == 2'd3) t_dng = i;
    end
    check_eq("pend_to_alarm", t_alarm - t_pend, ENTRY);
    check_eq("alarm_to_danger", t_dng - t_alarm, ESC);
    iSENSOR = 1'b0;
    press_key();
    check_eq("disarm_danger", int'(oMESG), 0);

    // ALARM with sensor dropping 25 cycles in: escalation counter restarts.
    press_key();
    iSENSOR = 1'b1;
    hold(44);
    iSENSOR = 1'b0;
    hold(6);
    iSENSOR = 1'b1;
    hold(20);
    check_eq("esc_restart_alarm", int'(oMESG), 2);
    hold(20);
    check_eq("esc_after_restart", int'(oMESG), 3);
    iSENSOR = 1'b0;
    press_key();

    // PENDING disarmed at timer=10: ALARM never reached.
    press_key();
    iSENSOR = 1'b1;
    hold(10);
    iKEY_ARM = 1'b0;
    alarm_seen = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (oMESG == 2'd2) alarm_seen = 1;
      if (i == 9) iKEY_ARM = 1'b1;
    end
    check_eq("pend_disarm_mesg", int'(oMESG), 0);
    check_eq("pend_no_alarm", alarm_seen, 0);
    iSENSOR = 1'b0;
    hold(10);

    // Glitches of 1..3 cycles do nothing.
    for (int g = 1; g <= 3; g++) begin
      iPANIC = 1'b1; hold(g); iPANIC = 1'b0; hold(8);
      iKEY_ARM = 1'b0; hold(g); iKEY_ARM = 1'b1; hold(8);
    end
    check_eq("glitch_mesg", int'(oMESG), 0);

    // Panic sustained, key ignored while panic held, honoured after release.
    iPANIC = 1'b1;
    hold(12);
    check_eq("panic_danger", int'(oMESG), 3);
    press_key();
    check_eq("key_panic_held", int'(oMESG), 3);
    iPANIC = 1'b0;
    hold(10);
    check_eq("panic_released", int'(oMESG), 3);
    press_key();
    check_eq("key_after_panic", int'(oMESG), 0);

    // Asynchronous reset mid-cycle in DANGER.
    iPANIC = 1'b1;
    hold(12);
    check_eq("pre_rst_buzzer", int'(oBUZZER), 1);
    #2;
    iRST_N = 1'b0;
    #1;
    check_eq("async_rst_mesg", int'(oMESG), 0);
    check_eq("async_rst_buzzer", int'(oBUZZER), 0);
    iPANIC = 1'b0;
    model_reset();
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    hold(20);

    // Randomized segments, mixing short glitches and long holds.
    for (int s = 0; s < 150; s++) begin
      iKEY_ARM = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      iSENSOR  = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
      iPANIC   = ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 2) == 0) hold($urandom_range(1, 3));
      else hold($urandom_range(4, 40));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
